// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory definitions: loader FSM states, memory geometry
// and the big-endian byte selector used by the write-port serializer.
package imem_pkg;

    localparam int unsigned IMEM_BYTES     = 256;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WRITE  = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    // Byte 0 is the most significant byte, matching the memory read order
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Instruction memory loader: takes 32-bit words from a valid/ready stream and
// writes them as four big-endian bytes. Optional IMEM_LOADER_CHECKSUM_EN adds checksum.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = IMEM_BYTES,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [31:0]                        s_data,
    input  logic                               s_last,
    output logic                               mem_we,
    output logic [31:0]                        mem_addr,
    output logic [7:0]                         mem_wdata,
    output logic                               cpu_stall,
    output logic                               load_done,
    output logic                               load_err,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [7:0]                         checksum,
`endif
    output logic [$clog2(MEM_BYTES/4):0]       word_count
);

    localparam int unsigned CNT_W = $clog2(MEM_BYTES / BYTES_PER_WORD) + 1;

    state_t             state_q, state_d;
    logic [31:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        word_q, word_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   count_d;
    logic               fits;
    logic               restart;
    logic               mem_we_d;
    logic [31:0]        mem_addr_d;
    logic [7:0]         mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         checksum_d;
`endif

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 32'(BASE_ADDR);
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            last_q     <= 1'b0;
            word_count <= '0;
            s_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'(BASE_ADDR);
            mem_wdata  <= 8'd0;
            cpu_stall  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            last_q     <= last_d;
            word_count <= count_d;
            s_ready    <= (state_d == ACCEPT);
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            cpu_stall  <= (state_d == ACCEPT) || (state_d == WRITE) || (state_d == ERROR);
            load_done  <= (state_d == DONE);
            load_err   <= (state_d == ERROR);
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum   <= checksum_d;
`endif
        end
    end

    // Widened compare so wr_ptr+4 cannot wrap
    assign fits = ({1'b0, wr_ptr_q} + 33'(BYTES_PER_WORD)) <= 33'(MEM_BYTES);

    // Next-state and serializer logic
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        last_d      = last_q;
        count_d     = word_count;
        restart     = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    restart  = 1'b1;
                    state_d  = ACCEPT;
                    wr_ptr_d = 32'(BASE_ADDR);
                    count_d  = '0;
                end
            end
            ACCEPT: begin
                if (s_valid && s_ready) begin
                    word_d     = s_data;
                    last_d     = s_last;
                    byte_idx_d = 2'd0;
                    state_d    = fits ? WRITE : ERROR;
                end
            end
            WRITE: begin
                wr_ptr_d   = wr_ptr_q + 32'd1;
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    count_d = word_count + CNT_W'(1);
                    state_d = last_q ? DONE : ACCEPT;
                end
            end
            default: state_d = IDLE;
        endcase

        // Write port presents the byte for the state being entered
        mem_we_d = (state_d == WRITE);
        if (mem_we_d) begin
            mem_addr_d  = wr_ptr_d;
            mem_wdata_d = word_byte(word_d, byte_idx_d);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        checksum_d = checksum;
        if (restart) begin
            checksum_d = 8'd0;
        end else if (mem_we_d) begin
            checksum_d = checksum + mem_wdata_d;
        end
`endif
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 16-byte memory; models the memory,
// logs every byte write and checks loads, backpressure, overflow and reset.
module tb_imem_loader;

    localparam int unsigned MEMB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_stall;
    logic        load_done;
    logic        load_err;
    logic [2:0]  word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    imem_loader #(.MEM_BYTES(MEMB), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_stall  (cpu_stall),
        .load_done  (load_done),
        .load_err   (load_err),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [0:63];
    logic [31:0] log_addr [0:63];
    logic [7:0]  log_data [0:63];
    int wr_cnt = 0;
    int oob    = 0;
    int bp_cnt = 0;
    int pcyc   = 0;
    int hs_first   = -1;
    int done_first = -1;
    logic stall_prev = 1'b0;
    logic stall_before_done = 1'b0;

    // Memory model and write/handshake monitor, sampled on the active edge
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[5:0]] = mem_wdata;
            if (wr_cnt < 64) begin
                log_addr[wr_cnt] = mem_addr;
                log_data[wr_cnt] = mem_wdata;
            end
            wr_cnt++;
            if (mem_addr >= MEMB) oob++;
        end
        if (s_valid && !s_ready && mem_we) bp_cnt++;
        if (s_valid && s_ready && hs_first < 0) hs_first = pcyc;
        if (load_done && done_first < 0) begin
            done_first = pcyc;
            stall_before_done = stall_prev;
        end
        stall_prev = cpu_stall;
        pcyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        oob = 0;
        bp_cnt = 0;
        hs_first = -1;
        done_first = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Holds s_valid until the word is taken; returns on the following negedge
    task automatic send(input logic [31:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check_eq("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!load_done && !load_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!load_done && !load_err) check_eq(tag, 32'd0, 32'd1);
    endtask

    logic [31:0] bp_words [0:2];
    logic [31:0] exp_w;

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'hEE;

        // Reset
        repeat (2) @(negedge clk);
        check_eq("rst_s_ready",   32'(s_ready),    32'd0);
        check_eq("rst_mem_we",    32'(mem_we),     32'd0);
        check_eq("rst_cpu_stall", 32'(cpu_stall),  32'd0);
        check_eq("rst_load_done", 32'(load_done),  32'd0);
        check_eq("rst_load_err",  32'(load_err),   32'd0);
        check_eq("rst_mem_addr",  mem_addr,        32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata),  32'd0);
        check_eq("rst_word_count",32'(word_count), 32'd0);
        check_eq("rst_mem_untouched", 32'(mem[0]), 32'hEE);
        rst_n = 1'b1;

        // Valid without start is ignored
        s_valid = 1'b1; s_data = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        check_eq("nostart_s_ready", 32'(s_ready), 32'd0);
        check_eq("nostart_writes",  32'(wr_cnt),  32'd0);
        s_valid = 1'b0;
        clear_log();

        // Basic two-word load
        pulse_start();
        check_eq("start_stall", 32'(cpu_stall), 32'd1);
        send(32'h20080005, 1'b0);
        send(32'h21090003, 1'b1);
        wait_end("basic_timeout");
        @(negedge clk);
        check_eq("basic_done",   32'(load_done),  32'd1);
        check_eq("basic_err",    32'(load_err),   32'd0);
        check_eq("basic_wc",     32'(word_count), 32'd2);
        check_eq("basic_stall",  32'(cpu_stall),  32'd0);
        check_eq("basic_writes", 32'(wr_cnt),     32'd8);
        check_eq("basic_latency", 32'(done_first - hs_first), 32'd10);
        check_eq("basic_stall_before_done", 32'(stall_before_done), 32'd1);
        check_eq("basic_b0", 32'(log_data[0]), 32'h20);
        check_eq("basic_b1", 32'(log_data[1]), 32'h08);
        check_eq("basic_b2", 32'(log_data[2]), 32'h00);
        check_eq("basic_b3", 32'(log_data[3]), 32'h05);
        check_eq("basic_b4", 32'(log_data[4]), 32'h21);
        check_eq("basic_b5", 32'(log_data[5]), 32'h09);
        check_eq("basic_b6", 32'(log_data[6]), 32'h00);
        check_eq("basic_b7", 32'(log_data[7]), 32'h03);
        for (int i = 0; i < 8; i++) check_eq($sformatf("basic_addr%0d", i), log_addr[i], 32'(i));

        // Back-to-back words with s_valid held through the writes
        clear_log();
        bp_words[0] = 32'hDEADBEEF; bp_words[1] = 32'h01234567; bp_words[2] = 32'h89ABCDEF;
        pulse_start();
        check_eq("restart_clears_done", 32'(load_done), 32'd0);
        for (int w = 0; w < 3; w++) send(bp_words[w], w == 2);
        wait_end("bp_timeout");
        check_eq("bp_writes",   32'(wr_cnt),     32'd12);
        check_eq("bp_stalled",  32'(bp_cnt > 0), 32'd1);
        check_eq("bp_wc",       32'(word_count), 32'd3);
        for (int i = 0; i < 12; i++) begin
            exp_w = bp_words[i/4] >> (8 * (3 - (i % 4)));
            check_eq($sformatf("bp_data%0d", i), 32'(log_data[i]), 32'(exp_w[7:0]));
            check_eq($sformatf("bp_addr%0d", i), log_addr[i], 32'(i));
        end

        // Overflow: fifth word of a 16-byte memory
        clear_log();
        pulse_start();
        for (int w = 0; w < 5; w++) send(32'h10203040 + 32'(w), 1'b0);
        wait_end("ovf_timeout");
        repeat (2) @(negedge clk);
        check_eq("ovf_err",    32'(load_err),   32'd1);
        check_eq("ovf_done",   32'(load_done),  32'd0);
        check_eq("ovf_stall",  32'(cpu_stall),  32'd1);
        check_eq("ovf_writes", 32'(wr_cnt),     32'd16);
        check_eq("ovf_oob",    32'(oob),        32'd0);
        check_eq("ovf_wc",     32'(word_count), 32'd4);
        check_eq("ovf_last_byte", 32'(mem[15]), 32'h43);

        // Clean reload after error
        clear_log();
        pulse_start();
        check_eq("reload_err_cleared", 32'(load_err), 32'd0);
        send(32'h11223344, 1'b1);
        wait_end("reload_timeout");
        check_eq("reload_done",  32'(load_done), 32'd1);
        check_eq("reload_err",   32'(load_err),  32'd0);
        check_eq("reload_stall", 32'(cpu_stall), 32'd0);
        check_eq("reload_m0",    32'(mem[0]),    32'h11);
        check_eq("reload_m3",    32'(mem[3]),    32'h44);

        // Reset after the second byte of a word
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        clear_log();
        pulse_start();
        send(32'hA1B2C3D4, 1'b1);
        for (int n = 0; n < 20 && wr_cnt < 2; n++) @(negedge clk);
        check_eq("mid_two_bytes", 32'(wr_cnt), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_we_low", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("mid_no_more_writes", 32'(wr_cnt <= 3), 32'd1);
        check_eq("mid_stall",   32'(cpu_stall),  32'd0);
        check_eq("mid_ready",   32'(s_ready),    32'd0);
        check_eq("mid_done",    32'(load_done),  32'd0);
        check_eq("mid_addr",    mem_addr,        32'd0);
        check_eq("mid_wc",      32'(word_count), 32'd0);
        check_eq("mid_m0",      32'(mem[0]),     32'hA1);
        check_eq("mid_m1",      32'(mem[1]),     32'hB2);
        check_eq("mid_m3",      32'(mem[3]),     32'hEE);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        send(32'h01020304, 1'b1);
        wait_end("cks1_timeout");
        check_eq("cks_first", 32'(checksum), 32'h0A);
        pulse_start();
        check_eq("cks_cleared", 32'(checksum), 32'h00);
        send(32'hFFFFFFFF, 1'b1);
        wait_end("cks2_timeout");
        check_eq("cks_second", 32'(checksum), 32'hFC);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot/program loader and write-port sequencer for the byte-wide instruction memory. It accepts 32-bit instruction words from a host over a valid/ready stream.
- Each word is written as four big-endian byte writes on the memory write port (We/write_address/write_data). This matches the memory's read order {addr, addr+1, addr+2, addr+3}.
- Holds the pipeline's fetch stage in stall while a load is in progress. Sits between the host/debug interface, the instruction memory write port and the hazard/stall logic.

Parameters:
MEM_BYTES, 256, instruction memory size in bytes; must be a power of two, >= 4
BASE_ADDR, 0, first byte address written on every load; must be a multiple of 4

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse that begins a load
s_valid  in  1  host word valid
s_ready  out  1  loader can accept a word
s_data  in  32  instruction word
s_last  in  1  marks final word of the program; qualified by s_valid
mem_we  out  1  instruction memory byte write enable
mem_addr  out  32  instruction memory write address
mem_wdata  out  8  instruction memory write byte
cpu_stall  out  1  freezes PC/fetch while high
load_done  out  1  sticky; program loaded successfully
load_err  out  1  sticky; overflow, program exceeded MEM_BYTES
word_count  out  $clog2(MEM_BYTES/4)+1  number of words written in current/last load

Behaviour:
- Reset, on the rising edge with rst_n=0:
  - state=IDLE; s_ready, mem_we, cpu_stall, load_done, load_err all 0.
  - mem_addr=BASE_ADDR, mem_wdata=0, word_count=0.
  - Memory contents are untouched (preloaded image remains runnable).
- States: IDLE, ACCEPT, WRITE, DONE, ERROR.
- IDLE:
  - start=1 -> ACCEPT next cycle; wr_ptr=BASE_ADDR, word_count=0, load_done=0, load_err=0, cpu_stall=1.
- ACCEPT:
  - s_ready=1.
  - On s_valid&s_ready: latch s_data and s_last, byte_idx=0.
    - If wr_ptr+4 <= MEM_BYTES -> WRITE.
    - Otherwise -> ERROR; no memory write occurs and the word is consumed.
- WRITE:
  - s_ready=0, mem_we=1, mem_addr=wr_ptr, mem_wdata=byte[3-byte_idx] of the latched word (byte_idx 0 -> bits 31:24).
  - Each cycle wr_ptr+=1, byte_idx+=1.
  - After byte_idx=3: word_count+=1; latched last=1 -> DONE, else -> ACCEPT.
  - Throughput: 1 word per 5 cycles (1 handshake + 4 writes).
- DONE: load_done=1, cpu_stall=0, mem_we=0.
- ERROR: load_err=1, cpu_stall=1 (CPU is held until a clean load completes), mem_we=0.
- start in DONE or ERROR restarts exactly as from IDLE.
- start in ACCEPT or WRITE is ignored.
- mem_we is asserted only in WRITE. mem_addr/mem_wdata hold their last value otherwise.
- Exact fit: wr_ptr==MEM_BYTES-4 with last -> DONE, no error.
- A word arriving in the same cycle as start is not accepted; s_ready only rises in ACCEPT.
- Reset mid-WRITE: aborts immediately; partially written word remains in memory; all outputs return to reset values.
- s_valid without start is ignored (s_ready=0).

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN
  - Defined: adds output checksum[7:0], the mod-256 sum of every byte written since the last start. It is cleared on start and on reset, and updates in the same cycle as each mem_we.
  - Not defined: port and adder absent; no other behaviour changes.

Decomposition:
- Shared package imem_pkg:
  - state enum {IDLE, ACCEPT, WRITE, DONE, ERROR} as a 3-bit typedef.
  - IMEM_BYTES=256 and BYTES_PER_WORD=4 constants, shared with the instruction memory.
- No sub-module needed; the byte serializer lives inline with the FSM.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all outputs 0, mem_addr=0, memory unchanged.
- Basic load:
  - Stimulus: start, words 0x20080005, 0x21090003 (last).
  - Writes 0x20,0x08,0x00,0x05 at addr 0-3, then 0x21,0x09,0x00,0x03 at addr 4-7.
  - load_done=1, word_count=2, cpu_stall falls the cycle DONE is entered; total 10 cycles from first handshake.
- Backpressure: s_valid held during WRITE -> s_ready=0, word not lost or duplicated; 3 words yield exactly 12 writes.
- Overflow, MEM_BYTES=16:
  - Stimulus: 5 words, none marked last.
  - Addresses 0-15 written; 5th word -> load_err=1, cpu_stall=1, no write to addr 16.
  - A subsequent start then a 1-word load -> load_done=1, load_err=0.
- Reset after 2nd byte of a word: writes stop, state IDLE, cpu_stall=0, bytes 0-1 retain new values.
- IMEM_LOADER_CHECKSUM_EN:
  - Stimulus: load 0x01020304 (last).
  - Result: checksum=0x0A; after restart and load of 0xFFFFFFFF, checksum=0xFC.
